// File: rtl/hpdl1414_uart_sink.sv
// hpdl1414_uart_sink
//   Takes bytes from a UART receiver and shows them on one HPDL1414
//   4-character display. The last four printable characters are kept in a
//   scrolling buffer, where digit 0 is the rightmost. Backspace and
//   clear codes edit that buffer. Every accepted byte rewrites all four
//   digits through the display's parallel write port, using programmable
//   setup, strobe and hold times.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous reset, active low
//   rx_data    in   [7:0] received byte, sampled only when rx_valid=1
//   rx_valid   in   one-cycle strobe, byte available
//   disp_data  out  [6:0] HPDL1414 D6..D0
//   disp_addr  out  [1:0] HPDL1414 A1..A0, digit 0 = rightmost
//   disp_wr_n  out  HPDL1414 write strobe, active low
//   busy       out  1 while a refresh sequence is running
//   overflow   out  sticky: a byte was dropped, cleared only by reset
module hpdl1414_uart_sink #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] disp_data,
  output logic [1:0] disp_addr,
  output logic       disp_wr_n,
  output logic       busy,
  output logic       overflow
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Each phase counter load value is (length - 1). The phase ends on the
  // edge where the counter reads zero.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d;
  logic [3:0][6:0] buf_q, buf_d;
  logic [7:0]      pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            ovf_q, ovf_d;
  logic            start_q, start_d;
  logic [1:0]      addr_q, addr_d;
  logic [6:0]      data_q, data_d;
  logic            wr_n_q, wr_n_d;

  logic            go;
  logic            take;
  logic [7:0]      byte_sel;

  function automatic logic is_accepted(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0C || b == 8'h0D;
  endfunction

  function automatic logic [3:0][6:0] apply_byte(input logic [7:0]      b,
                                                 input logic [3:0][6:0] cur);
    logic [3:0][6:0] r;
    r = cur;
    if (b >= 8'h20 && b <= 8'h5F) begin
      r = {cur[2:0], b[6:0]};
    end else if (b >= 8'h60 && b <= 8'h7E) begin
      r = {cur[2:0], 7'(b[6:0] - 7'h20)};
    end else if (b == 8'h08) begin
      r = {7'h20, cur[3:1]};
    end else if (b == 8'h0C || b == 8'h0D) begin
      r = {4{7'h20}};
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    buf_d      = buf_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = ovf_q;
    start_d    = start_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_n_d     = wr_n_q;
    go         = 1'b0;
    take       = 1'b0;
    byte_sel   = rx_data;

    // While refreshing, and on the power-on refresh cycle, new bytes can
    // only be parked in the single pending slot. Anything beyond that is lost.
    if ((state_q != S_IDLE || start_q) && rx_valid) begin
      if (!pend_vld_q) begin
        pend_d     = rx_data;
        pend_vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        wr_n_d = 1'b1;
        if (start_q) begin
          start_d = 1'b0;
          go      = 1'b1;
        end else if (pend_vld_q) begin
          // The parked byte is decoded first. A byte arriving on the
          // same cycle takes over the slot it frees.
          take       = 1'b1;
          byte_sel   = pend_q;
          pend_vld_d = rx_valid;
          if (rx_valid) pend_d = rx_data;
        end else if (rx_valid) begin
          take = 1'b1;
        end
        if (take && is_accepted(byte_sel)) begin
          buf_d = apply_byte(byte_sel, buf_q);
          go    = 1'b1;
        end
        if (go) begin
          state_d = S_SETUP;
          dig_d   = 2'd0;
          addr_d  = 2'd0;
          data_d  = buf_d[0];
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = PULSE_LD;
          wr_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (dig_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SETUP;
            dig_d   = dig_q + 2'd1;
            addr_d  = dig_q + 2'd1;
            data_d  = buf_q[dig_q + 2'd1];
            cnt_d   = SETUP_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dig_q      <= 2'd0;
      buf_q      <= {4{7'h20}};
      pend_q     <= 8'h00;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      start_q    <= 1'b1;
      addr_q     <= 2'd0;
      data_q     <= 7'h20;
      wr_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      buf_q      <= buf_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_n_q     <= wr_n_d;
    end
  end

  assign disp_data = data_q;
  assign disp_addr = addr_q;
  assign disp_wr_n = wr_n_q;
  assign busy      = (state_q != S_IDLE);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_hpdl1414_uart_sink.sv
module tb_hpdl1414_uart_sink;
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 4;
  localparam int HOLD_CYC  = 2;
  localparam int T = 4 * (SETUP_CYC + PULSE_CYC + HOLD_CYC);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [6:0] disp_data;
  logic [1:0] disp_addr;
  logic       disp_wr_n;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  hpdl1414_uart_sink #(
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .disp_data(disp_data),
    .disp_addr(disp_addr),
    .disp_wr_n(disp_wr_n),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, req, req);
    end
  endfunction

  function automatic void check_ge(input string name, input int act, input int req);
    checks++;
    if (act < req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected at least %0d", name, $time, act, req);
    end
  endfunction

  // Reference model. The text is held left to right, so digit d is text[3-d].
  // Time is counted in refresh-sized busy windows. There are no FSM phases.
  logic [7:0] text[$];
  logic [7:0] pend[$];
  logic [8:0] exp_q[$];
  int         busy_left = 0;
  bit         m_start = 1'b1;
  bit         m_ovf = 1'b0;

  function automatic void m_refresh();
    for (int d = 0; d < 4; d++) begin
      logic [7:0] c;
      c = text[3-d];
      exp_q.push_back({2'(d), c[6:0]});
    end
    busy_left = T;
  endfunction

  function automatic void m_process(input logic [7:0] b);
    bit acc;
    acc = 1'b1;
    if (b >= 8'h20 && b <= 8'h5F) begin
      text.delete(0);
      text.push_back(b);
    end else if (b >= 8'h60 && b <= 8'h7E) begin
      text.delete(0);
      text.push_back(b - 8'h20);
    end else if (b == 8'h08) begin
      text.delete(3);
      text.push_front(8'h20);
    end else if (b == 8'h0C || b == 8'h0D) begin
      text = {8'h20, 8'h20, 8'h20, 8'h20};
    end else begin
      acc = 1'b0;
    end
    if (acc) m_refresh();
  endfunction

  function automatic void m_capture(input bit v, input logic [7:0] b);
    if (v) begin
      if (pend.size() == 0) pend.push_back(b);
      else m_ovf = 1'b1;
    end
  endfunction

  // Advance the model by one clock edge, using the inputs applied at that edge.
  function automatic void model_step(input bit v, input logic [7:0] b);
    if (!rst_n) begin
      text = {8'h20, 8'h20, 8'h20, 8'h20};
      pend.delete();
      exp_q.delete();
      busy_left = 0;
      m_start = 1'b1;
      m_ovf = 1'b0;
    end else if (m_start) begin
      m_start = 1'b0;
      m_capture(v, b);
      m_refresh();
    end else if (busy_left > 0) begin
      m_capture(v, b);
      busy_left--;
    end else if (pend.size() != 0) begin
      logic [7:0] p;
      p = pend.pop_front();
      if (v) pend.push_back(b);
      m_process(p);
    end else if (v) begin
      m_process(b);
    end
  endfunction

  task automatic cyc(input bit v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = b;
    @(posedge clk);
    #1;
    model_step(v, b);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    cyc(1'b1, b);
    idle(gap);
  endtask

  // Monitor: compares every write strobe against the scoreboard and checks
  // the write-port timing and the busy/overflow flags on every cycle.
  logic [8:0] prev_ad = '0;
  bit         prev_wr = 1'b1;
  int         since_chg = 0;
  int         low_cnt = 0;
  int         since_rise = 0;
  bit         have_rise = 1'b0;

  always @(negedge clk) begin
    logic [8:0] ad;
    logic [8:0] e;
    ad = {disp_addr, disp_data};
    if (!rst_n) begin
      prev_ad   = ad;
      prev_wr   = 1'b1;
      since_chg = 0;
      low_cnt   = 0;
      have_rise = 1'b0;
    end else begin
      check("busy", int'(busy), int'(busy_left != 0));
      check("overflow", int'(overflow), int'(m_ovf));
      if (ad != prev_ad) begin
        check("addr_data_change_while_wr_low", int'(disp_wr_n), 1);
        if (have_rise) check_ge("hold_cycles", since_rise, HOLD_CYC);
        since_chg = 1;
      end else begin
        since_chg++;
      end
      if (!disp_wr_n && prev_wr) begin
        check_ge("setup_cycles", since_chg, SETUP_CYC + 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write at %0t: got addr %0d data 0x%0h expected no write", $time, disp_addr, disp_data);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", int'(disp_addr), int'(e[8:7]));
          check("write_data", int'(disp_data), int'(e[6:0]));
        end
        low_cnt = 1;
      end else if (!disp_wr_n) begin
        low_cnt++;
      end else if (!prev_wr) begin
        check("pulse_width", low_cnt, PULSE_CYC);
        since_rise = 1;
        have_rise  = 1'b1;
      end else begin
        since_rise++;
      end
      prev_ad = ad;
      prev_wr = disp_wr_n;
    end
  end

  function automatic logic [7:0] rand_byte();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 4)      return 8'($urandom_range(8'h20, 8'h5F));
    else if (k <= 6) return 8'($urandom_range(8'h60, 8'h7E));
    else if (k == 7) return 8'h08;
    else if (k == 8) return ($urandom_range(0, 1) != 0) ? 8'h0C : 8'h0D;
    else             return 8'($urandom_range(0, 255));
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy_left != 0 || pend.size() != 0) && n < 20 * T) begin
      idle(1);
      n++;
    end
    check(name, int'(n < 20 * T), 1);
  endtask

  initial begin
    text = {8'h20, 8'h20, 8'h20, 8'h20};
    rst_n = 1'b0;
    idle(3);
    check("reset_wr_n", int'(disp_wr_n), 1);
    check("reset_addr", int'(disp_addr), 0);
    check("reset_data", int'(disp_data), 8'h20);
    check("reset_busy", int'(busy), 0);
    check("reset_overflow", int'(overflow), 0);

    // Power-on blank, then the directed character sequence
    rst_n = 1'b1;
    idle(T + 5);
    send(8'h41, T + 3);
    send(8'h42, T + 3);
    send(8'h43, T + 3);
    send(8'h44, T + 3);
    send(8'h65, T + 3);
    send(8'h08, T + 3);
    send(8'h0D, T + 3);
    send(8'h07, T + 3);
    check("ignored_code_idle", int'(busy), 0);

    // Three bytes back to back: the third one has nowhere to go
    cyc(1'b1, 8'h58);
    cyc(1'b1, 8'h59);
    cyc(1'b1, 8'h5A);
    check("xyz_overflow", int'(overflow), 1);
    idle(3 * T);

    // Random traffic with a mix of spaced and crowded arrivals
    for (int i = 0; i < 250; i++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, T + 4);
      send(rand_byte(), gap);
    end
    drain("drain_random_timeout");
    idle(2);

    // Reset landing in the middle of a strobe
    send(8'h51, 0);
    begin
      int n;
      n = 0;
      while (disp_wr_n && n < 4 * T) begin
        idle(1);
        n++;
      end
      check("strobe_seen_before_reset", int'(n < 4 * T), 1);
    end
    rst_n = 1'b0;
    idle(1);
    check("abort_wr_n", int'(disp_wr_n), 1);
    idle(1);
    check("abort_busy", int'(busy), 0);
    check("abort_overflow", int'(overflow), 0);
    check("abort_data", int'(disp_data), 8'h20);
    rst_n = 1'b1;
    idle(T + 5);
    drain("drain_final_timeout");
    idle(4);
    check("leftover_writes", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t: got no finish expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
